video_sig_recover: RTL and testbench

Receive-side counterpart to the video timing generator. Takes a raw sync/data-enable stream (hs_in, vs_in, ad_in) from a camera or HDMI front end and reconstructs active-region pixel coordinates, a new-frame strobe and a frame counter. It also measures line and frame totals and declares lock once the incoming timing matches the configured format for a programmable number of consecutive frames. It sits between the input PHY and the pixel-processing pipeline, which qualifies its data with locked_out.

---
 rtl/video_sig_recover.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_video_sig_recover.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_sig_recover.sv
// -----------------------------------------------------------------------------
// video_sig_recover
//
// Receive-side timing recovery. Rebuilds active-region pixel coordinates, a
// new-frame strobe and a frame counter from a raw hs/vs/ad stream. It also
// measures line and frame totals and reports lock once the incoming timing
// has matched the configured format for LOCK_FRAMES consecutive frames.
//
// Ports
//   pixel_clk_in  : pixel clock, all logic on its rising edge
//   rst_n_in      : asynchronous active-low reset
//   hs_in         : horizontal sync, active high
//   vs_in         : vertical sync, active high
//   ad_in         : active-data enable, active high
//   hcount_out    : pixel index within the active line
//   vcount_out    : active line index
//   ad_out        : ad_in delayed two cycles, aligned with the counters
//   nf_out        : one-cycle new-frame strobe (after the last active line)
//   fc_out        : frame counter, modulo FPS, advances only while locked
//   locked_out    : incoming timing matches the configured format
//   h_total_out   : last measured hs-to-hs period in cycles
//   v_total_out   : last measured number of hs edges per vs period
// -----------------------------------------------------------------------------
module video_sig_recover #(
    parameter int ACTIVE_H_PIXELS = 1280,
    parameter int H_FRONT_PORCH   = 110,
    parameter int H_SYNC_WIDTH    = 40,
    parameter int H_BACK_PORCH    = 220,
    parameter int ACTIVE_LINES    = 720,
    parameter int V_FRONT_PORCH   = 5,
    parameter int V_SYNC_WIDTH    = 5,
    parameter int V_BACK_PORCH    = 20,
    parameter int FPS             = 60,
    parameter int LOCK_FRAMES     = 2,
    localparam int TOTAL_PIXELS   = ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH,
    localparam int TOTAL_LINES    = ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH,
    localparam int HW             = $clog2(TOTAL_PIXELS),
    localparam int VW             = $clog2(TOTAL_LINES),
    localparam int FW             = $clog2(FPS)
) (
    input  logic          pixel_clk_in,
    input  logic          rst_n_in,
    input  logic          hs_in,
    input  logic          vs_in,
    input  logic          ad_in,
    output logic [HW-1:0] hcount_out,
    output logic [VW-1:0] vcount_out,
    output logic          ad_out,
    output logic          nf_out,
    output logic [FW-1:0] fc_out,
    output logic          locked_out,
    output logic [HW:0]   h_total_out,
    output logic [VW:0]   v_total_out
);

    localparam int GW = $clog2(LOCK_FRAMES + 1);

    localparam logic [HW:0]   TOTAL_PIXELS_C = (HW+1)'(TOTAL_PIXELS);
    localparam logic [HW:0]   ACTIVE_H_C     = (HW+1)'(ACTIVE_H_PIXELS);
    localparam logic [VW:0]   TOTAL_LINES_C  = (VW+1)'(TOTAL_LINES);
    localparam logic [VW:0]   ACTIVE_LINES_C = (VW+1)'(ACTIVE_LINES);
    localparam logic [VW-1:0] LAST_LINE_C    = VW'(ACTIVE_LINES - 1);
    localparam logic [FW-1:0] FC_LAST_C      = FW'(FPS - 1);
    localparam logic [GW-1:0] LOCK_FRAMES_C  = GW'(LOCK_FRAMES);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_CHECK  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    // input pipeline: smp = first register stage, dly = second stage
    logic hs_smp_r, vs_smp_r, ad_smp_r;
    logic hs_dly_r, vs_dly_r, ad_dly_r;

    logic hs_rise_s, vs_rise_s, ad_rise_s, ad_fall_s;

    logic [HW-1:0] hcount_r;
    logic [VW-1:0] vcount_r;
    logic          arm_r;

    logic [HW:0]   hper_r;
    logic [HW:0]   h_total_r;
    logic          hs_seen_r;
    logic [HW:0]   ad_run_r;

    logic [VW:0]   hs_cnt_r;
    logic [VW:0]   line_cnt_r;
    logic [VW:0]   v_total_r;
    logic          vs_seen_r;

    logic          frame_bad_r;
    logic [1:0]    state_r;
    logic [1:0]    state_nxt_s;
    logic [GW-1:0] good_cnt_r;
    logic [GW-1:0] good_nxt_s;
    logic [GW-1:0] good_inc_s;
    logic          locked_r;
    logic          nf_r;
    logic [FW-1:0] fc_r;

    logic          hper_bad_s;
    logic          run_bad_s;
    logic          timeout_s;
    logic          nf_hit_s;
    logic [VW:0]   hs_cnt_close_s;
    logic [VW:0]   line_cnt_close_s;
    logic          frame_bad_close_s;

    assign hs_rise_s = hs_smp_r & ~hs_dly_r;
    assign vs_rise_s = vs_smp_r & ~vs_dly_r;
    assign ad_rise_s = ad_smp_r & ~ad_dly_r;
    assign ad_fall_s = ~ad_smp_r & ad_dly_r;

    // An hs period is judged only once a previous hs edge gave it a start point.
    assign hper_bad_s = hs_rise_s & hs_seen_r & (hper_r != TOTAL_PIXELS_C);
    assign run_bad_s  = ad_fall_s & (ad_run_r != ACTIVE_H_C);
    // No hs where one was due: the period counter has run past a full line.
    assign timeout_s  = (hper_r > TOTAL_PIXELS_C);
    assign nf_hit_s   = ad_fall_s & (vcount_r == LAST_LINE_C) & (state_r == ST_LOCKED);
    assign good_inc_s = good_cnt_r + {{(GW-1){1'b0}}, 1'b1};

    // Edges coinciding with the closing vs edge belong to the closing frame.
    assign hs_cnt_close_s   = (hs_rise_s && (hs_cnt_r != {(VW+1){1'b1}})) ?
                              hs_cnt_r + {{VW{1'b0}}, 1'b1} : hs_cnt_r;
    assign line_cnt_close_s = (ad_rise_s && (line_cnt_r != {(VW+1){1'b1}})) ?
                              line_cnt_r + {{VW{1'b0}}, 1'b1} : line_cnt_r;
    assign frame_bad_close_s = frame_bad_r | hper_bad_s | run_bad_s |
                               (line_cnt_close_s != ACTIVE_LINES_C) |
                               (hs_cnt_close_s != TOTAL_LINES_C);

    // Two-stage input pipeline used for edge detection and ad alignment.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            hs_smp_r <= 1'b0;
            vs_smp_r <= 1'b0;
            ad_smp_r <= 1'b0;
            hs_dly_r <= 1'b0;
            vs_dly_r <= 1'b0;
            ad_dly_r <= 1'b0;
        end else begin
            hs_smp_r <= hs_in;
            vs_smp_r <= vs_in;
            ad_smp_r <= ad_in;
            hs_dly_r <= hs_smp_r;
            vs_dly_r <= vs_smp_r;
            ad_dly_r <= ad_smp_r;
        end
    end

    // Pixel and active-line coordinates; vcount restarts on the first line after vs.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            hcount_r <= {HW{1'b0}};
            vcount_r <= {VW{1'b0}};
            arm_r    <= 1'b0;
        end else begin
            if (ad_rise_s) begin
                hcount_r <= {HW{1'b0}};
            end else if (hcount_r != {HW{1'b1}}) begin
                hcount_r <= hcount_r + {{(HW-1){1'b0}}, 1'b1};
            end else begin
                hcount_r <= hcount_r;
            end

            if (ad_rise_s && arm_r) begin
                vcount_r <= {VW{1'b0}};
            end else if (ad_rise_s && (vcount_r != {VW{1'b1}})) begin
                vcount_r <= vcount_r + {{(VW-1){1'b0}}, 1'b1};
            end else begin
                vcount_r <= vcount_r;
            end

            if (vs_rise_s) begin
                arm_r <= 1'b1;
            end else if (ad_rise_s) begin
                arm_r <= 1'b0;
            end else begin
                arm_r <= arm_r;
            end
        end
    end

    // Horizontal measurement: hs period and ad run length.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            hper_r    <= {(HW+1){1'b0}};
            h_total_r <= {(HW+1){1'b0}};
            hs_seen_r <= 1'b0;
            ad_run_r  <= {(HW+1){1'b0}};
        end else begin
            if (hs_rise_s) begin
                hper_r    <= {{HW{1'b0}}, 1'b1};
                hs_seen_r <= 1'b1;
                h_total_r <= hs_seen_r ? hper_r : h_total_r;
            end else begin
                hper_r    <= (hper_r != {(HW+1){1'b1}}) ? hper_r + {{HW{1'b0}}, 1'b1} : hper_r;
                hs_seen_r <= hs_seen_r;
                h_total_r <= h_total_r;
            end

            if (ad_rise_s) begin
                ad_run_r <= {{HW{1'b0}}, 1'b1};
            end else if (ad_smp_r && (ad_run_r != {(HW+1){1'b1}})) begin
                ad_run_r <= ad_run_r + {{HW{1'b0}}, 1'b1};
            end else begin
                ad_run_r <= ad_run_r;
            end
        end
    end

    // Vertical measurement and the per-frame bad flag.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            hs_cnt_r    <= {(VW+1){1'b0}};
            line_cnt_r  <= {(VW+1){1'b0}};
            v_total_r   <= {(VW+1){1'b0}};
            vs_seen_r   <= 1'b0;
            frame_bad_r <= 1'b0;
        end else if (vs_rise_s) begin
            hs_cnt_r    <= {(VW+1){1'b0}};
            line_cnt_r  <= {(VW+1){1'b0}};
            v_total_r   <= vs_seen_r ? hs_cnt_close_s : v_total_r;
            vs_seen_r   <= 1'b1;
            frame_bad_r <= 1'b0;
        end else begin
            hs_cnt_r    <= hs_cnt_close_s;
            line_cnt_r  <= line_cnt_close_s;
            v_total_r   <= v_total_r;
            vs_seen_r   <= vs_seen_r;
            frame_bad_r <= frame_bad_r | hper_bad_s | run_bad_s;
        end
    end

    // Lock FSM next-state; a missing hs overrides everything.
    always_comb begin
        state_nxt_s = state_r;
        good_nxt_s  = good_cnt_r;
        if (timeout_s) begin
            state_nxt_s = ST_SEARCH;
            good_nxt_s  = {GW{1'b0}};
        end else if (vs_rise_s) begin
            case (state_r)
                ST_SEARCH: begin
                    state_nxt_s = ST_CHECK;
                    good_nxt_s  = {GW{1'b0}};
                end
                ST_CHECK: begin
                    if (frame_bad_close_s) begin
                        state_nxt_s = ST_CHECK;
                        good_nxt_s  = {GW{1'b0}};
                    end else if (good_inc_s >= LOCK_FRAMES_C) begin
                        state_nxt_s = ST_LOCKED;
                        good_nxt_s  = good_inc_s;
                    end else begin
                        state_nxt_s = ST_CHECK;
                        good_nxt_s  = good_inc_s;
                    end
                end
                ST_LOCKED: begin
                    if (frame_bad_close_s) begin
                        state_nxt_s = ST_CHECK;
                        good_nxt_s  = {GW{1'b0}};
                    end else begin
                        state_nxt_s = ST_LOCKED;
                        good_nxt_s  = good_cnt_r;
                    end
                end
                default: begin
                    state_nxt_s = ST_SEARCH;
                    good_nxt_s  = {GW{1'b0}};
                end
            endcase
        end else begin
            state_nxt_s = state_r;
            good_nxt_s  = good_cnt_r;
        end
    end

    // Lock FSM state, lock flag, new-frame strobe and frame counter.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r    <= ST_SEARCH;
            good_cnt_r <= {GW{1'b0}};
            locked_r   <= 1'b0;
            nf_r       <= 1'b0;
            fc_r       <= {FW{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            good_cnt_r <= good_nxt_s;
            locked_r   <= (state_nxt_s == ST_LOCKED);
            nf_r       <= nf_hit_s;
            if (nf_hit_s) begin
                fc_r <= (fc_r == FC_LAST_C) ? {FW{1'b0}} : fc_r + {{(FW-1){1'b0}}, 1'b1};
            end else begin
                fc_r <= fc_r;
            end
        end
    end

    assign hcount_out  = hcount_r;
    assign vcount_out  = vcount_r;
    assign ad_out      = ad_dly_r;
    assign nf_out      = nf_r;
    assign fc_out      = fc_r;
    assign locked_out  = locked_r;
    assign h_total_out = h_total_r;
    assign v_total_out = v_total_r;

endmodule

// File: tb/tb_video_sig_recover.sv
// -----------------------------------------------------------------------------
// tb_video_sig_recover
//
// Directed bench for video_sig_recover using a reduced format so whole frames
// stay short: 8 active + 2/2/3 blanking pixels (15 per line), 4 active + 1/1/2
// blanking lines (8 per frame), FPS = 3, LOCK_FRAMES = 2. A small in-bench
// timing generator drives hs/vs/ad; expected values come from the generator
// position two cycles earlier and from hand-derived lock/total values.
// -----------------------------------------------------------------------------
module tb_video_sig_recover;

    localparam int AH = 8, HFP = 2, HSW = 2, HBP = 3, TP = 15;
    localparam int AL = 4, VFP = 1, VSW = 1, VBP = 2, TL = 8;
    localparam int FPS_P = 3, LOCKF = 2;
    localparam int HW = $clog2(TP), VW = $clog2(TL), FW = $clog2(FPS_P);

    logic          pixel_clk_in = 1'b0;
    logic          rst_n_in = 1'b0;
    logic          hs_in = 1'b0;
    logic          vs_in = 1'b0;
    logic          ad_in = 1'b0;
    logic [HW-1:0] hcount_out;
    logic [VW-1:0] vcount_out;
    logic          ad_out;
    logic          nf_out;
    logic [FW-1:0] fc_out;
    logic          locked_out;
    logic [HW:0]   h_total_out;
    logic [VW:0]   v_total_out;

    video_sig_recover #(
        .ACTIVE_H_PIXELS(AH), .H_FRONT_PORCH(HFP), .H_SYNC_WIDTH(HSW), .H_BACK_PORCH(HBP),
        .ACTIVE_LINES(AL), .V_FRONT_PORCH(VFP), .V_SYNC_WIDTH(VSW), .V_BACK_PORCH(VBP),
        .FPS(FPS_P), .LOCK_FRAMES(LOCKF)
    ) dut (
        .pixel_clk_in(pixel_clk_in),
        .rst_n_in(rst_n_in),
        .hs_in(hs_in),
        .vs_in(vs_in),
        .ad_in(ad_in),
        .hcount_out(hcount_out),
        .vcount_out(vcount_out),
        .ad_out(ad_out),
        .nf_out(nf_out),
        .fc_out(fc_out),
        .locked_out(locked_out),
        .h_total_out(h_total_out),
        .v_total_out(v_total_out)
    );

    always #5 pixel_clk_in = ~pixel_clk_in;

    int checks = 0;
    int failures = 0;

    // generator state
    int hc = 0, vc = 0, iter = 0;
    bit gen_run = 1'b0, vs_mode = 1'b0, sup_arm = 1'b0, short_arm = 1'b0;
    int vs_rise_iter = -100, sup_iter = -100;
    int fc_exp = 0;
    // history of driven positions; [0] = last cycle, [1] = two cycles back
    int h_hc[2], h_vc[2];
    bit h_ad[2], h_lf[2];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed=%0d expected=%0d (iter %0d)", tag, obs, exp, iter);
        end
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_hcount"}, 32'(hcount_out), 32'd0);
        check_val({tag, "_vcount"}, 32'(vcount_out), 32'd0);
        check_val({tag, "_ad"}, 32'(ad_out), 32'd0);
        check_val({tag, "_nf"}, 32'(nf_out), 32'd0);
        check_val({tag, "_fc"}, 32'(fc_out), 32'd0);
        check_val({tag, "_locked"}, 32'(locked_out), 32'd0);
        check_val({tag, "_h_total"}, 32'(h_total_out), 32'd0);
        check_val({tag, "_v_total"}, 32'(v_total_out), 32'd0);
    endtask

    task automatic clear_hist();
        for (int k = 0; k < 2; k++) begin
            h_hc[k] = 0; h_vc[k] = 0; h_ad[k] = 1'b0; h_lf[k] = 1'b0;
        end
    endtask

    // One pixel cycle: check outputs against the position driven two cycles
    // earlier, then drive the next generator position.
    task automatic step();
        int  p, vstart;
        bit  hs_n, vs_n, ad_n, lf_n, nf_exp;
        @(negedge pixel_clk_in);
        iter++;
        check_val("ad_align", 32'(ad_out), 32'(h_ad[1]));
        if (ad_out && locked_out) begin
            check_val("hcount", 32'(hcount_out), 32'(h_hc[1]));
            check_val("vcount", 32'(vcount_out), 32'(h_vc[1]));
        end
        nf_exp = locked_out && h_lf[1];
        if (nf_exp) fc_exp = (fc_exp + 1) % FPS_P;
        check_val("nf", 32'(nf_out), 32'(nf_exp));
        check_val("fc", 32'(fc_out), 32'(fc_exp));

        hs_n = 1'b0; vs_n = 1'b0; ad_n = 1'b0; lf_n = 1'b0;
        if (gen_run) begin
            p      = vc * TP + hc;
            vstart = (AL + VFP) * TP + (vs_mode ? (AH + HFP) : 0);
            hs_n   = (hc >= AH + HFP) && (hc < AH + HFP + HSW);
            ad_n   = (hc < AH) && (vc < AL);
            vs_n   = (p >= vstart) && (p < vstart + VSW * TP);
            lf_n   = (hc == AH) && (vc == AL - 1);
            if (sup_arm && vc == 1 && hs_n) begin
                hs_n = 1'b0;
                if (hc == AH + HFP) sup_iter = iter;
                if (hc == AH + HFP + HSW - 1) sup_arm = 1'b0;
            end
            if (short_arm && vc == 1 && hc == AH - 1) begin
                ad_n = 1'b0;
                short_arm = 1'b0;
            end
            hc++;
            if (hc == TP) begin
                hc = 0;
                vc = (vc == TL - 1) ? 0 : vc + 1;
            end
        end
        if (vs_n && !vs_in) vs_rise_iter = iter;
        hs_in = hs_n; vs_in = vs_n; ad_in = ad_n;
        h_hc[1] = h_hc[0]; h_vc[1] = h_vc[0]; h_ad[1] = h_ad[0]; h_lf[1] = h_lf[0];
        h_hc[0] = hc == 0 ? TP - 1 : hc - 1;
        h_vc[0] = (hc == 0) ? ((vc == 0) ? TL - 1 : vc - 1) : vc;
        h_ad[0] = ad_n; h_lf[0] = lf_n;
        if (!gen_run) begin
            h_hc[0] = 0; h_vc[0] = 0;
        end
    endtask

    // Run until a vs rising edge has been driven, then one more cycle; the
    // caller sees the old lock state now and the new one after one more step.
    task automatic to_vs();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (vs_rise_iter != iter && n < 400);
        if (vs_rise_iter != iter) check_val("vs_wait_timeout", 32'd0, 32'd1);
        step();
    endtask

    task automatic lock_sequence(input string tag);
        to_vs();
        check_val({tag, "_vs1_pre"}, 32'(locked_out), 32'd0);
        step();
        check_val({tag, "_vs1_locked"}, 32'(locked_out), 32'd0);
        check_val({tag, "_vs1_v_total"}, 32'(v_total_out), 32'd0);
        check_val({tag, "_vs1_h_total"}, 32'(h_total_out), 32'(TP));
        to_vs();
        step();
        check_val({tag, "_vs2_locked"}, 32'(locked_out), 32'd0);
        check_val({tag, "_vs2_v_total"}, 32'(v_total_out), 32'(TL));
        to_vs();
        check_val({tag, "_vs3_pre"}, 32'(locked_out), 32'd0);
        step();
        check_val({tag, "_vs3_locked"}, 32'(locked_out), 32'd1);
    endtask

    // Drop reset between clock edges and restart the generator at frame start.
    task automatic mid_reset(input string tag);
        #2;
        rst_n_in = 1'b0;
        #1;
        check_zero(tag);
        gen_run = 1'b0;
        hs_in = 1'b0; vs_in = 1'b0; ad_in = 1'b0;
        hc = 0; vc = 0; fc_exp = 0;
        clear_hist();
        repeat (3) @(negedge pixel_clk_in);
        check_zero({tag, "_held"});
        rst_n_in = 1'b1;
        gen_run = 1'b1;
    endtask

    initial begin
        int n;
        clear_hist();
        repeat (3) @(negedge pixel_clk_in);
        check_zero("rst_init");
        rst_n_in = 1'b1;
        gen_run = 1'b1;

        // acquire lock from a clean start, then hold it across frames
        lock_sequence("s1");
        repeat (4) begin
            to_vs();
            step();
            check_val("s1_hold_locked", 32'(locked_out), 32'd1);
        end
        check_val("s1_h_total", 32'(h_total_out), 32'(TP));
        check_val("s1_v_total", 32'(v_total_out), 32'(TL));

        // one ad run of AH-1 pixels: lock drops only at the closing vs edge
        short_arm = 1'b1;
        to_vs();
        check_val("short_pre", 32'(locked_out), 32'd1);
        step();
        check_val("short_fall", 32'(locked_out), 32'd0);
        to_vs();
        step();
        check_val("short_good1", 32'(locked_out), 32'd0);
        to_vs();
        step();
        check_val("short_relock", 32'(locked_out), 32'd1);

        // missing hs pulse: timeout drops lock mid-frame
        sup_iter = -100;
        sup_arm = 1'b1;
        n = 0;
        while (iter != sup_iter + 2 && n < 400) begin
            step();
            n++;
        end
        if (iter != sup_iter + 2) check_val("sup_wait_timeout", 32'd0, 32'd1);
        check_val("sup_pre", 32'(locked_out), 32'd1);
        step();
        check_val("sup_fall", 32'(locked_out), 32'd0);
        n = 0;
        while (iter != sup_iter + 17 && n < 40) begin
            step();
            n++;
        end
        check_val("sup_h_total", 32'(h_total_out), 32'(2 * TP));
        to_vs();
        step();
        check_val("sup_vsA", 32'(locked_out), 32'd0);
        to_vs();
        step();
        check_val("sup_vsB", 32'(locked_out), 32'd0);
        to_vs();
        step();
        check_val("sup_relock", 32'(locked_out), 32'd1);

        // asynchronous reset mid-frame, then the same acquisition again
        repeat (37) step();
        mid_reset("rst_mid");
        lock_sequence("s4");

        // vs rising together with hs: that hs closes the frame
        repeat (20) step();
        mid_reset("rst_vsmode");
        vs_mode = 1'b1;
        lock_sequence("s5");
        to_vs();
        step();
        check_val("s5_hold_locked", 32'(locked_out), 32'd1);
        check_val("s5_v_total", 32'(v_total_out), 32'(TL));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
